// File: rtl/motor_step_ctrl.sv
// motor_step_ctrl: runs a BCD-entered absolute move on one of six stepper motors.
// Converts the three digits to binary, compares the target with the tracked
// position of the selected motor, then emits |target - pos| step pulses with the
// matching direction level. Owns the only copy of each motor's position.
// Optional feature macro: STEP_ABORT_EN -- a new Enter edge during a move aborts it.
module motor_step_ctrl #(
  parameter int STEP_DIV = 25000,
  parameter int POS_W    = 10
) (
  input  logic       sysclk,
  input  logic       INIT,
  input  logic       Enter,
  input  logic [5:0] Motor,
  input  logic [3:0] TValue0,
  input  logic [3:0] TValue1,
  input  logic [3:0] TValue2,
  output logic [5:0] Step,
  output logic [5:0] Dir,
  output logic       Busy,
  output logic       Done,
  output logic       Err
);

  // Counter must hold STEP_DIV-1 for the step phases and 1 for the SETUP wait.
  localparam int CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPT    = 3'd1,
    S_CALC    = 3'd2,
    S_SETUP   = 3'd3,
    S_STEP_HI = 3'd4,
    S_STEP_LO = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             enter_q, edge_q;
  logic [5:0]       motor_q, motor_d;
  logic [3:0]       dig0_q, dig0_d, dig1_q, dig1_d, dig2_q, dig2_d;
  logic [POS_W-1:0] target_q, target_d;
  logic             invalid_q, invalid_d;
  logic [2:0]       midx_q, midx_d;
  logic [POS_W-1:0] remain_q, remain_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] pos_q [6];
  logic [POS_W-1:0] pos_d [6];
  logic [5:0]       step_q, step_d, dir_q, dir_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [POS_W-1:0] target_calc, cur_pos, diff;
  logic [2:0]       idx_calc;
  logic             invalid_calc, gt, eq, phase_last, moving, abort_w, step_end, last_step;

  assign Step = step_q;
  assign Dir  = dir_q;
  assign Busy = busy_q;
  assign Done = done_q;
  assign Err  = err_q;

`ifdef STEP_ABORT_EN
  assign abort_w = edge_q;
`else
  assign abort_w = 1'b0;
`endif

  assign target_calc = POS_W'(dig0_q) * POS_W'(100) + POS_W'(dig1_q) * POS_W'(10) + POS_W'(dig2_q);
  assign invalid_calc = !$onehot(motor_q) || (dig0_q > 4'd9) || (dig1_q > 4'd9) || (dig2_q > 4'd9);
  assign cur_pos    = pos_q[midx_q];
  assign gt         = target_q > cur_pos;
  assign eq         = target_q == cur_pos;
  assign diff       = gt ? (target_q - cur_pos) : (cur_pos - target_q);
  assign phase_last = cnt_q == CNT_LAST;
  assign moving     = (state_q == S_SETUP) || (state_q == S_STEP_HI) || (state_q == S_STEP_LO);
  assign step_end   = (state_q == S_STEP_LO) && phase_last && !abort_w;
  assign last_step  = step_end && (remain_q == POS_W'(1));

  // One-hot select to motor index; only meaningful when the select is valid.
  always_comb begin
    idx_calc = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (motor_q[i]) idx_calc = 3'(i);
    end
  end

  // Enter synchroniser history and registered rising-edge strobe.
  always_ff @(posedge sysclk or posedge INIT) begin
    if (INIT) begin
      enter_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      enter_q <= Enter;
      edge_q  <= Enter & ~enter_q;
    end
  end

  // FSM state register.
  always_ff @(posedge sysclk or posedge INIT) begin
    if (INIT) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state logic; SETUP lasts two cycles so Step rises well after Dir settles.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (edge_q) state_d = S_CAPT;
      S_CAPT:    state_d = S_CALC;
      S_CALC:    state_d = (invalid_q || eq) ? S_IDLE : S_SETUP;
      S_SETUP:   if (abort_w) state_d = S_IDLE;
                 else if (cnt_q == CNT_ONE) state_d = S_STEP_HI;
      S_STEP_HI: if (abort_w) state_d = S_IDLE;
                 else if (phase_last) state_d = S_STEP_LO;
      S_STEP_LO: if (abort_w) state_d = S_IDLE;
                 else if (phase_last) state_d = (remain_q == POS_W'(1)) ? S_IDLE : S_STEP_HI;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs and datapath next values.
  always_comb begin
    motor_d   = motor_q;
    dig0_d    = dig0_q;
    dig1_d    = dig1_q;
    dig2_d    = dig2_q;
    target_d  = target_q;
    invalid_d = invalid_q;
    midx_d    = midx_q;
    remain_d  = remain_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    cnt_d     = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
    step_d    = '0;
    if (state_d == S_STEP_HI) step_d[midx_q] = 1'b1;
    busy_d    = state_d != S_IDLE;
    done_d    = ((state_q == S_CALC) && !invalid_q && eq) || last_step;
    err_d     = ((state_q == S_CALC) && invalid_q) || (abort_w && moving);
    if ((state_q == S_IDLE) && edge_q) begin
      motor_d = Motor;
      dig0_d  = TValue0;
      dig1_d  = TValue1;
      dig2_d  = TValue2;
    end
    if (state_q == S_CAPT) begin
      target_d  = target_calc;
      invalid_d = invalid_calc;
      midx_d    = idx_calc;
    end
    if ((state_q == S_CALC) && !invalid_q && !eq) begin
      dir_d[midx_q] = gt;
      remain_d      = diff;
    end
    if (step_end) begin
      pos_d[midx_q] = dir_q[midx_q] ? (cur_pos + POS_W'(1)) : (cur_pos - POS_W'(1));
      remain_d      = remain_q - POS_W'(1);
    end
  end

  // Datapath, position table and registered output pins.
  always_ff @(posedge sysclk or posedge INIT) begin
    if (INIT) begin
      motor_q   <= '0;
      dig0_q    <= '0;
      dig1_q    <= '0;
      dig2_q    <= '0;
      target_q  <= '0;
      invalid_q <= 1'b0;
      midx_q    <= '0;
      remain_q  <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < 6; i++) pos_q[i] <= '0;
      step_q    <= '0;
      dir_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      motor_q   <= motor_d;
      dig0_q    <= dig0_d;
      dig1_q    <= dig1_d;
      dig2_q    <= dig2_d;
      target_q  <= target_d;
      invalid_q <= invalid_d;
      midx_q    <= midx_d;
      remain_q  <= remain_d;
      cnt_q     <= cnt_d;
      pos_q     <= pos_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

endmodule
